// File: rtl/layer_mem_if.sv
// Layer-memory port bundle: accelerator read/write strobes, dump stream and status outputs.
// master = accelerator/consumer side, slave = memory responder side.
interface layer_mem_if #(
    parameter int DW    = 13,
    parameter int CNT_W = 13
);
    logic             cwr;
    logic             csel;
    logic [11:0]      caddr_wr;
    logic [DW-1:0]    cdata_wr;
    logic             crd;
    logic [11:0]      caddr_rd;
    logic [DW-1:0]    cdata_rd;
    logic             dump_start;
    logic             dump_sel;
    logic             dump_busy;
    logic             dump_valid;
    logic             dump_ready;
    logic [11:0]      dump_addr;
    logic [DW-1:0]    dump_data;
    logic             dump_last;
    logic             err_oob;
    logic [CNT_W-1:0] wr_cnt0;
    logic [CNT_W-1:0] wr_cnt1;

    modport master (
        output cwr, csel, caddr_wr, cdata_wr, crd, caddr_rd,
        output dump_start, dump_sel, dump_ready,
        input  cdata_rd, dump_busy, dump_valid, dump_addr, dump_data, dump_last,
        input  err_oob, wr_cnt0, wr_cnt1
    );

    modport slave (
        input  cwr, csel, caddr_wr, cdata_wr, crd, caddr_rd,
        input  dump_start, dump_sel, dump_ready,
        output cdata_rd, dump_busy, dump_valid, dump_addr, dump_data, dump_last,
        output err_oob, wr_cnt0, wr_cnt1
    );
endinterface

// File: rtl/layer_mem_responder.sv
// Two-bank layer memory (64x64 conv map, 32x32 pool map) with 1-cycle accelerator reads,
// read-before-write, and a valid/ready dump stream at up to 1 word per 2 cycles.
module layer_mem_responder #(
    parameter int DW    = 13,
    parameter int L0_AW = 12,
    parameter int L1_AW = 10,
    parameter int CNT_W = 13
) (
    input  logic       clk,
    input  logic       reset,
    layer_mem_if.slave bus
);
    localparam int L0_DEPTH = 1 << L0_AW;
    localparam int L1_DEPTH = 1 << L1_AW;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} dump_state_t;

    logic [DW-1:0] mem0 [L0_DEPTH];
    logic [DW-1:0] mem1 [L1_DEPTH];

    logic             wr_oob, rd_oob, wr_en0, wr_en1;
    logic [DW-1:0]    cdata_rd_q;
    logic [CNT_W-1:0] wr_cnt0_q, wr_cnt1_q;
    logic             err_oob_q;

    dump_state_t      state_q, state_d;
    logic             sel_q;
    logic [L0_AW-1:0] ptr_q;
    logic             dump_valid_q, dump_last_q;
    logic [L0_AW-1:0] dump_addr_q;
    logic [DW-1:0]    dump_data_q;
    logic             start_en, fetch_en, advance;
    logic             fetch_blocked, ptr_at_end;

    // Bank 1 only decodes the low L1_AW bits; any upper bit set is out of range.
    assign wr_oob = bus.csel && (bus.caddr_wr[11:L1_AW] != '0);
    assign rd_oob = bus.csel && (bus.caddr_rd[11:L1_AW] != '0);
    assign wr_en0 = bus.cwr && !bus.csel;
    assign wr_en1 = bus.cwr && bus.csel && !wr_oob;

    always_ff @(posedge clk) begin
        if (wr_en0) mem0[bus.caddr_wr[L0_AW-1:0]] <= bus.cdata_wr;
        if (wr_en1) mem1[bus.caddr_wr[L1_AW-1:0]] <= bus.cdata_wr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cdata_rd_q <= '0;
        end else if (bus.crd) begin
            if (!bus.csel)  cdata_rd_q <= mem0[bus.caddr_rd[L0_AW-1:0]];
            else if (rd_oob) cdata_rd_q <= '0;
            else             cdata_rd_q <= mem1[bus.caddr_rd[L1_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt0_q <= '0;
            wr_cnt1_q <= '0;
            err_oob_q <= 1'b0;
        end else begin
            if (wr_en0 && (wr_cnt0_q != '1)) wr_cnt0_q <= wr_cnt0_q + 1'b1;
            if (wr_en1 && (wr_cnt1_q != '1)) wr_cnt1_q <= wr_cnt1_q + 1'b1;
            if ((bus.cwr && wr_oob) || (bus.crd && rd_oob)) err_oob_q <= 1'b1;
        end
    end

    // The accelerator owns the bank's read port; the dump fetch yields and retries.
    assign fetch_blocked = bus.crd && (bus.csel == sel_q);
    assign ptr_at_end    = sel_q ? (ptr_q == L0_AW'(L1_DEPTH - 1))
                                 : (ptr_q == L0_AW'(L0_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start_en = 1'b0;
        fetch_en = 1'b0;
        advance  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dump_start) begin
                    start_en = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (!fetch_blocked) begin
                    fetch_en = 1'b1;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.dump_ready) begin
                    advance = 1'b1;
                    state_d = dump_last_q ? IDLE : FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q        <= 1'b0;
            ptr_q        <= '0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_last_q  <= 1'b0;
        end else begin
            if (start_en) begin
                sel_q <= bus.dump_sel;
                ptr_q <= '0;
            end
            if (fetch_en) begin
                dump_valid_q <= 1'b1;
                dump_addr_q  <= ptr_q;
                dump_last_q  <= ptr_at_end;
                dump_data_q  <= sel_q ? mem1[ptr_q[L1_AW-1:0]] : mem0[ptr_q];
            end
            if (advance) begin
                dump_valid_q <= 1'b0;
                ptr_q        <= ptr_q + 1'b1;
            end
        end
    end

    assign bus.cdata_rd   = cdata_rd_q;
    assign bus.wr_cnt0    = wr_cnt0_q;
    assign bus.wr_cnt1    = wr_cnt1_q;
    assign bus.err_oob    = err_oob_q;
    assign bus.dump_busy  = (state_q != IDLE);
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = dump_data_q;
    assign bus.dump_last  = dump_last_q;
endmodule
